// File: rtl/uart_receiver.sv
// 8N1 UART receiver sampling a 16x-oversampled serial line.
// Each correctly framed byte is presented on data_in together with a one-cycle rx_done strobe.
module uart_receiver #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       clk_baud,
    input  logic       rx_in,
    output logic [7:0] data_in,
    output logic       rx_done,
    output logic       frame_error,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);
    localparam logic [2:0] IDX_LAST  = 3'(DBIT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       ferr_q, ferr_d;
    logic       busy_q, busy_d;
    logic       sync1_q, sync2_q;
    logic       rx_s;

    assign rx_s        = sync2_q;
    assign data_in     = data_q;
    assign rx_done     = done_q;
    assign frame_error = ferr_q;
    assign busy        = busy_q;

    // Next-state and output decode for the receive FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Start detection runs every clk_in cycle, not only on ticks
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (clk_baud) begin
                    if (cnt_q == 4'd7) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            cnt_d   = 4'd0;
                            idx_d   = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DATA: begin
                if (clk_baud) begin
                    if (cnt_q == 4'd15) begin
                        sh_d  = {rx_s, sh_q[7:1]};
                        cnt_d = 4'd0;
                        if (idx_q == IDX_LAST) begin
                            state_d = STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            STOP: begin
                if (clk_baud) begin
                    if (cnt_q == STOP_LAST) begin
                        state_d = IDLE;
                        if (rx_s) begin
                            data_d = sh_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers plus the rx_in synchronizer
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 3'd0;
            sh_q    <= 8'h00;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

endmodule
